// File: rtl/control_unit.sv
// control_unit: sequencer in front of the CPU datapath. It runs the
// three-cycle fetch, decodes ir[31:27] and steps through the execute
// micro-operations for each instruction class. The state moves back to
// T0 after each instruction, or to HALT when a halt opcode is fetched.
// Optional build macro CU_INSTR_COUNT_EN adds a completed-instruction
// counter on output instr_count.
module control_unit (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic [7:0]  reg_out,
  output logic [9:0]  reg_in,
  output logic [2:0]  gr_sel,
  output logic        rin,
  output logic        rout,
  output logic        BAout,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        run
`ifdef CU_INSTR_COUNT_EN
  ,
  output logic [31:0] instr_count
`endif
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  // reg_out bit positions
  localparam int RO_PC = 0, RO_MDR = 1, RO_RZLO = 3, RO_C = 7;
  // reg_in bit positions
  localparam int RI_PC = 0, RI_IR = 1, RI_MAR = 2, RI_MDR = 3, RI_RY = 4,
                 RI_RZ = 5, RI_CON = 8;
  // {gra, grb, grc}
  localparam logic [2:0] GRA = 3'b100, GRB = 3'b010, GRC = 3'b001;

  state_t     state_q, state_d;
  logic [4:0] op;
  logic       is_ld, is_ldi, is_st, is_ralu, is_ialu, is_br, is_halt;
  logic       unused_ir;

  assign op        = ir[31:27];
  assign unused_ir = ^ir[26:0];

  // Opcode class decode; anything unrecognised falls through as a nop.
  always_comb begin
    is_ld   = (op == 5'b00000);
    is_ldi  = (op == 5'b00001);
    is_st   = (op == 5'b00010);
    is_ralu = (op >= 5'b00011) && (op <= 5'b01011);
    is_ialu = (op >= 5'b01100) && (op <= 5'b01110);
    is_br   = (op == 5'b10010);
    is_halt = (op == 5'b11010);
  end

  // State register; clear aborts any instruction immediately.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= S_RST;
    else        state_q <= state_d;
  end

  // Next-state and strobe decode from state and opcode class.
  always_comb begin
    state_d = state_q;
    reg_out = '0;
    reg_in  = '0;
    gr_sel  = '0;
    rin     = 1'b0;
    rout    = 1'b0;
    BAout   = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    Write   = 1'b0;
    run     = 1'b1;
    case (state_q)
      S_RST: begin
        run     = 1'b0;
        state_d = S_T0;
      end
      S_T0: begin
        reg_out[RO_PC] = 1'b1;
        reg_in[RI_MAR] = 1'b1;
        IncPC          = 1'b1;
        state_d        = S_T1;
      end
      S_T1: begin
        Read           = 1'b1;
        reg_in[RI_MDR] = 1'b1;
        state_d        = S_T2;
      end
      S_T2: begin
        // The branch out of T2 looks at the opcode presented during T2.
        reg_out[RO_MDR] = 1'b1;
        reg_in[RI_IR]   = 1'b1;
        if (is_halt)
          state_d = S_HALT;
        else if (is_ld || is_ldi || is_st || is_ralu || is_ialu || is_br)
          state_d = S_T3;
        else
          state_d = S_T0;
      end
      S_T3: begin
        state_d = S_T4;
        if (is_br) begin
          gr_sel         = GRA;
          rout           = 1'b1;
          reg_in[RI_CON] = 1'b1;
        end else begin
          gr_sel        = GRB;
          reg_in[RI_RY] = 1'b1;
          if (is_ld || is_st || is_ldi) BAout = 1'b1;
          else                          rout  = 1'b1;
        end
      end
      S_T4: begin
        state_d = S_T5;
        if (is_ralu) begin
          gr_sel        = GRC;
          rout          = 1'b1;
          reg_in[RI_RZ] = 1'b1;
        end else if (is_br) begin
          reg_out[RO_PC] = 1'b1;
          reg_in[RI_RY]  = 1'b1;
        end else begin
          reg_out[RO_C] = 1'b1;
          reg_in[RI_RZ] = 1'b1;
        end
      end
      S_T5: begin
        if (is_br) begin
          reg_out[RO_C] = 1'b1;
          reg_in[RI_RZ] = 1'b1;
          state_d       = S_T6;
        end else if (is_ld || is_st) begin
          reg_out[RO_RZLO] = 1'b1;
          reg_in[RI_MAR]   = 1'b1;
          state_d          = S_T6;
        end else begin
          reg_out[RO_RZLO] = 1'b1;
          gr_sel           = GRA;
          rin              = 1'b1;
          state_d          = S_T0;
        end
      end
      S_T6: begin
        if (is_br) begin
          reg_out[RO_RZLO] = 1'b1;
          reg_in[RI_PC]    = con_ff;
          state_d          = S_T0;
        end else if (is_st) begin
          gr_sel         = GRA;
          rout           = 1'b1;
          reg_in[RI_MDR] = 1'b1;
          state_d        = S_T7;
        end else begin
          Read           = 1'b1;
          reg_in[RI_MDR] = 1'b1;
          state_d        = S_T7;
        end
      end
      S_T7: begin
        state_d = S_T0;
        if (is_st) begin
          Write = 1'b1;
        end else begin
          reg_out[RO_MDR] = 1'b1;
          gr_sel          = GRA;
          rin             = 1'b1;
        end
      end
      S_HALT: begin
        run     = 1'b0;
        state_d = S_HALT;
      end
      default: begin
        run     = 1'b0;
        state_d = S_RST;
      end
    endcase
  end

`ifdef CU_INSTR_COUNT_EN
  logic [31:0] instr_count_q;

  assign instr_count = instr_count_q;

  // Count every instruction that completes, including the halt itself.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)
      instr_count_q <= '0;
    else if (run && (state_d == S_T0 || state_d == S_HALT))
      instr_count_q <= instr_count_q + 32'd1;
  end
`endif

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: stimulus pushes hand-written strobe vectors
// into a queue, a monitor pops one per falling edge and compares.
module tb_control_unit;

  logic        clock;
  logic        clear;
  logic [31:0] ir;
  logic        con_ff;
  logic [7:0]  reg_out;
  logic [9:0]  reg_in;
  logic [2:0]  gr_sel;
  logic        rin, rout, BAout, IncPC, Read, Write, run;
`ifdef CU_INSTR_COUNT_EN
  logic [31:0] instr_count;
`endif

  control_unit dut (
    .clock   (clock),
    .clear   (clear),
    .ir      (ir),
    .con_ff  (con_ff),
    .reg_out (reg_out),
    .reg_in  (reg_in),
    .gr_sel  (gr_sel),
    .rin     (rin),
    .rout    (rout),
    .BAout   (BAout),
    .IncPC   (IncPC),
    .Read    (Read),
    .Write   (Write),
    .run     (run)
`ifdef CU_INSTR_COUNT_EN
    ,
    .instr_count (instr_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reg_out / reg_in one-hot names
  localparam logic [7:0] PCOUT = 8'h01, MDROUT = 8'h02, RZLO = 8'h08, COUT = 8'h80;
  localparam logic [9:0] PCIN = 10'h001, IRIN = 10'h002, MARIN = 10'h004,
                         MDRIN = 10'h008, RYIN = 10'h010, RZIN = 10'h020,
                         CONIN = 10'h100, NONE = 10'h000;
  localparam logic [2:0] GA = 3'b100, GB = 3'b010, GC = 3'b001, G0 = 3'b000;

  typedef struct {
    string      name;
    logic [27:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // {reg_out, reg_in, gr_sel, rin, rout, BAout, IncPC, Read, Write, run}
  function automatic logic [27:0] mk(input logic [7:0] ro, input logic [9:0] ri,
                                     input logic [2:0] gs, input logic r_in,
                                     input logic r_out, input logic ba,
                                     input logic inc, input logic rd,
                                     input logic wr, input logic rn);
    return {ro, ri, gs, r_in, r_out, ba, inc, rd, wr, rn};
  endfunction

  task automatic push(input string name, input logic [27:0] v);
    exp_t e;
    e.name = name;
    e.v    = v;
    exp_q.push_back(e);
  endtask

  task automatic push_zero(input string name);
    push(name, 28'h0);
  endtask

  task automatic push_fetch(input string tag);
    push({tag, "_T0"}, mk(PCOUT, MARIN, G0, 0, 0, 0, 1, 0, 0, 1));
    push({tag, "_T1"}, mk(8'h00, MDRIN, G0, 0, 0, 0, 0, 1, 0, 1));
    push({tag, "_T2"}, mk(MDROUT, IRIN, G0, 0, 0, 0, 0, 0, 0, 1));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic direct_check(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: one expected vector per cycle, sampled mid-cycle.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [27:0] act;
      e   = exp_q.pop_front();
      act = {reg_out, reg_in, gr_sel, rin, rout, BAout, IncPC, Read, Write, run};
      n_chk++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %07h expected %07h", e.name, act, e.v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear  = 1'b0;
    ir     = 32'h0;
    con_ff = 1'b0;

    // Held in reset: everything low.
    @(posedge clock); #1;
    push_zero("rst_a");
    push_zero("rst_b");
    cycles(2);
    clear = 1'b1;
    push_zero("rst_release");
    cycles(1);

    // add (R-ALU)
    ir = 32'h1800_0000;
    push_fetch("add");
    push("add_T3", mk(8'h00, RYIN, GB, 0, 1, 0, 0, 0, 0, 1));
    push("add_T4", mk(8'h00, RZIN, GC, 0, 1, 0, 0, 0, 0, 1));
    push("add_T5", mk(RZLO, NONE, GA, 1, 0, 0, 0, 0, 0, 1));
    cycles(6);

    // ldi
    ir = 32'h0800_0000;
    push_fetch("ldi");
    push("ldi_T3", mk(8'h00, RYIN, GB, 0, 0, 1, 0, 0, 0, 1));
    push("ldi_T4", mk(COUT, RZIN, G0, 0, 0, 0, 0, 0, 0, 1));
    push("ldi_T5", mk(RZLO, NONE, GA, 1, 0, 0, 0, 0, 0, 1));
    cycles(6);

    // I-ALU, op 01100
    ir = 32'h6000_0000;
    push_fetch("ialu");
    push("ialu_T3", mk(8'h00, RYIN, GB, 0, 1, 0, 0, 0, 0, 1));
    push("ialu_T4", mk(COUT, RZIN, G0, 0, 0, 0, 0, 0, 0, 1));
    push("ialu_T5", mk(RZLO, NONE, GA, 1, 0, 0, 0, 0, 0, 1));
    cycles(6);

    // ld
    ir = 32'h0000_0000;
    push_fetch("ld");
    push("ld_T3", mk(8'h00, RYIN, GB, 0, 0, 1, 0, 0, 0, 1));
    push("ld_T4", mk(COUT, RZIN, G0, 0, 0, 0, 0, 0, 0, 1));
    push("ld_T5", mk(RZLO, MARIN, G0, 0, 0, 0, 0, 0, 0, 1));
    push("ld_T6", mk(8'h00, MDRIN, G0, 0, 0, 0, 0, 1, 0, 1));
    push("ld_T7", mk(MDROUT, NONE, GA, 1, 0, 0, 0, 0, 0, 1));
    cycles(8);

    // st
    ir = 32'h1000_0000;
    push_fetch("st");
    push("st_T3", mk(8'h00, RYIN, GB, 0, 0, 1, 0, 0, 0, 1));
    push("st_T4", mk(COUT, RZIN, G0, 0, 0, 0, 0, 0, 0, 1));
    push("st_T5", mk(RZLO, MARIN, G0, 0, 0, 0, 0, 0, 0, 1));
    push("st_T6", mk(8'h00, MDRIN, GA, 0, 1, 0, 0, 0, 0, 1));
    push("st_T7", mk(8'h00, NONE, G0, 0, 0, 0, 0, 0, 1, 1));
    cycles(8);

    // br taken
    ir = 32'h9000_0000;
    con_ff = 1'b1;
    push_fetch("br1");
    push("br1_T3", mk(8'h00, CONIN, GA, 0, 1, 0, 0, 0, 0, 1));
    push("br1_T4", mk(PCOUT, RYIN, G0, 0, 0, 0, 0, 0, 0, 1));
    push("br1_T5", mk(COUT, RZIN, G0, 0, 0, 0, 0, 0, 0, 1));
    push("br1_T6", mk(RZLO, PCIN, G0, 0, 0, 0, 0, 0, 0, 1));
    cycles(7);

    // br not taken
    con_ff = 1'b0;
    push_fetch("br0");
    push("br0_T3", mk(8'h00, CONIN, GA, 0, 1, 0, 0, 0, 0, 1));
    push("br0_T4", mk(PCOUT, RYIN, G0, 0, 0, 0, 0, 0, 0, 1));
    push("br0_T5", mk(COUT, RZIN, G0, 0, 0, 0, 0, 0, 0, 1));
    push("br0_T6", mk(RZLO, NONE, G0, 0, 0, 0, 0, 0, 0, 1));
    cycles(7);

    // nop, then an unassigned opcode behaving as nop
    ir = 32'hC800_0000;
    push_fetch("nop");
    cycles(3);
    ir = 32'h8000_0000;
    push_fetch("unk");
    cycles(3);

`ifdef CU_INSTR_COUNT_EN
    direct_check("count_before_reset", instr_count, 32'd9);
`endif

    // Reset in the middle of T4 of an add.
    ir = 32'h1800_0000;
    push_fetch("add2");
    push("add2_T3", mk(8'h00, RYIN, GB, 0, 1, 0, 0, 0, 0, 1));
    cycles(4);
    clear = 1'b0;
    #1;
    direct_check("rst_mid_immediate",
                 {4'h0, reg_out, reg_in, gr_sel, rin, rout, BAout, IncPC, Read, Write, run},
                 32'h0);
    push_zero("rst_mid");
    cycles(1);
    clear = 1'b1;
    push_zero("rst_mid_release");
    cycles(1);

    // halt, then a garbage opcode while halted
    ir = 32'hD000_0000;
    push_fetch("halt");
    cycles(3);
    ir = 32'hF800_0000;
    push_zero("halt_a");
    push_zero("halt_b");
    push_zero("halt_c");
    push_zero("halt_d");
    cycles(4);

`ifdef CU_INSTR_COUNT_EN
    direct_check("count_after_halt", instr_count, 32'd1);
`endif

    @(negedge clock); #1;
    direct_check("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
